// File: rtl/nco_pkg.sv
// Shared types and default widths for the NCO sweep phase generator family.
package nco_pkg;

    localparam int PHASE_WIDTH = 32;
    localparam int DWELL_WIDTH = 16;

    localparam logic [DWELL_WIDTH-1:0] DWELL_RESET = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [PHASE_WIDTH-1:0] start_fcw;
        logic [PHASE_WIDTH-1:0] stop_fcw;
        logic [PHASE_WIDTH-1:0] step_fcw;
        logic [DWELL_WIDTH-1:0] dwell;
        logic [PHASE_WIDTH-1:0] phase0;
        logic                   loop;
    } sweep_cfg_t;

    // A dwell of 0 behaves as 1, so both reload the counter with 0.
    function automatic logic [DWELL_WIDTH-1:0] dwell_reload(input logic [DWELL_WIDTH-1:0] dwell);
        return (dwell == '0) ? '0 : dwell - 1'b1;
    endfunction

endpackage

// File: rtl/nco_sweep_phase_gen_phase_accumulator.sv
// Phase accumulator: loads an initial phase, then adds the FCW each enabled cycle.
module phase_accumulator #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_phase,
    input  logic             enable,
    input  logic [WIDTH-1:0] fcw,
    output logic [WIDTH-1:0] phase
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (load) begin
            phase <= load_phase;
        end else if (enable) begin
            phase <= phase + fcw;
        end
    end

endmodule

// File: rtl/nco_sweep_phase_gen.sv
// Linear FCW sweep (chirp) phase generator feeding the sine LUT phase input.
module nco_sweep_phase_gen
    import nco_pkg::*;
#(
    parameter int PHASE_WIDTH = nco_pkg::PHASE_WIDTH,
    parameter int DWELL_WIDTH = nco_pkg::DWELL_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PHASE_WIDTH-1:0] cfg_start_fcw,
    input  logic [PHASE_WIDTH-1:0] cfg_stop_fcw,
    input  logic [PHASE_WIDTH-1:0] cfg_step_fcw,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [PHASE_WIDTH-1:0] cfg_phase0,
    input  logic                   cfg_loop,
    input  logic                   start,
    input  logic                   abort,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic                   phase_valid,
    output logic [PHASE_WIDTH-1:0] fcw,
    output logic                   busy,
    output logic                   done,
    output logic                   sweep_wrap
);

    state_e                 state, state_nxt;
    sweep_cfg_t             shadow, port_cfg, eff_cfg;
    logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_cnt_nxt;
    logic [PHASE_WIDTH-1:0] fcw_nxt;
    logic [PHASE_WIDTH:0]   fcw_sum;
    logic                   step_ok;
    logic                   sweep_wrap_nxt;
    logic                   acc_load;
    logic                   acc_en;
    logic                   cfg_fire;

    assign port_cfg = '{start_fcw: cfg_start_fcw, stop_fcw: cfg_stop_fcw, step_fcw: cfg_step_fcw,
                        dwell: cfg_dwell, phase0: cfg_phase0, loop: cfg_loop};

    assign cfg_ready = (state == IDLE);
    assign cfg_fire  = cfg_valid && cfg_ready;
    // A config beat arriving with start is used directly instead of waiting for the shadow.
    assign eff_cfg   = cfg_fire ? port_cfg : shadow;

    // One extra bit catches a carry past 2^PHASE_WIDTH, which ends the sweep.
    assign fcw_sum = {1'b0, fcw} + {1'b0, shadow.step_fcw};
    assign step_ok = !fcw_sum[PHASE_WIDTH] && (fcw_sum[PHASE_WIDTH-1:0] <= shadow.stop_fcw);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '{start_fcw: '0, stop_fcw: '0, step_fcw: '0,
                        dwell: DWELL_RESET, phase0: '0, loop: 1'b0};
        end else if (cfg_fire) begin
            shadow <= port_cfg;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt      = state;
        fcw_nxt        = fcw;
        dwell_cnt_nxt  = dwell_cnt;
        sweep_wrap_nxt = 1'b0;
        acc_load       = 1'b0;
        acc_en         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = RUN;
                    acc_load      = 1'b1;
                    fcw_nxt       = eff_cfg.start_fcw;
                    dwell_cnt_nxt = dwell_reload(eff_cfg.dwell);
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    acc_en = 1'b1;
                    if (dwell_cnt != '0) begin
                        dwell_cnt_nxt = dwell_cnt - 1'b1;
                    end else if (step_ok) begin
                        fcw_nxt       = fcw_sum[PHASE_WIDTH-1:0];
                        dwell_cnt_nxt = dwell_reload(shadow.dwell);
                    end else if (shadow.loop) begin
                        fcw_nxt        = shadow.start_fcw;
                        dwell_cnt_nxt  = dwell_reload(shadow.dwell);
                        sweep_wrap_nxt = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            fcw        <= '0;
            dwell_cnt  <= '0;
            sweep_wrap <= 1'b0;
        end else begin
            state      <= state_nxt;
            fcw        <= fcw_nxt;
            dwell_cnt  <= dwell_cnt_nxt;
            sweep_wrap <= sweep_wrap_nxt;
        end
    end

    phase_accumulator #(.WIDTH(PHASE_WIDTH)) u_phase_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (acc_load),
        .load_phase (eff_cfg.phase0),
        .enable     (acc_en),
        .fcw        (fcw),
        .phase      (phase)
    );

    assign phase_valid = (state == RUN);
    assign busy        = (state == RUN);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_nco_sweep_phase_gen.sv
// Self-checking bench: sweep-sequence model compared every cycle, plus literal expectations.
module tb_nco_sweep_phase_gen;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_start_fcw;
    logic [31:0] cfg_stop_fcw;
    logic [31:0] cfg_step_fcw;
    logic [15:0] cfg_dwell;
    logic [31:0] cfg_phase0;
    logic        cfg_loop;
    logic        start;
    logic        abort;
    logic [31:0] phase;
    logic        phase_valid;
    logic [31:0] fcw;
    logic        busy;
    logic        done;
    logic        sweep_wrap;

    nco_sweep_phase_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_start_fcw (cfg_start_fcw),
        .cfg_stop_fcw  (cfg_stop_fcw),
        .cfg_step_fcw  (cfg_step_fcw),
        .cfg_dwell     (cfg_dwell),
        .cfg_phase0    (cfg_phase0),
        .cfg_loop      (cfg_loop),
        .start         (start),
        .abort         (abort),
        .phase         (phase),
        .phase_valid   (phase_valid),
        .fcw           (fcw),
        .busy          (busy),
        .done          (done),
        .sweep_wrap    (sweep_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int wrap_cnt = 0;
    bit saw_fcw_wrapped = 1'b0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a sweep is the list of FCW values applied on each RUN cycle.
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    localparam int SEQ_CAP = 4096;
    int          m_mode;
    int          m_idx;
    logic [31:0] m_phase, m_fcw;
    bit          m_wrap;
    logic [31:0] s_start, s_stop, s_step, s_phase0;
    logic [15:0] s_dwell;
    bit          s_loop;
    logic [31:0] seq[$];

    task automatic build_seq();
        longint unsigned f, nf;
        int d;
        seq.delete();
        d = (s_dwell == 0) ? 1 : int'(s_dwell);
        f = s_start;
        forever begin
            for (int i = 0; i < d; i++) seq.push_back(f[31:0]);
            nf = f + s_step;
            if (nf > s_stop || nf > 64'hFFFF_FFFF || seq.size() >= SEQ_CAP) break;
            f = nf;
        end
    endtask

    task automatic model_step();
        m_wrap = 1'b0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_phase = '0; m_fcw = '0;
            s_start = '0; s_stop = '0; s_step = '0; s_phase0 = '0; s_dwell = 16'd1; s_loop = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (cfg_valid) begin
                        s_start = cfg_start_fcw; s_stop = cfg_stop_fcw; s_step = cfg_step_fcw;
                        s_dwell = cfg_dwell; s_phase0 = cfg_phase0; s_loop = cfg_loop;
                    end
                    if (start) begin
                        build_seq();
                        m_mode = M_RUN; m_idx = 0; m_phase = s_phase0; m_fcw = seq[0];
                    end
                end
                M_RUN: begin
                    if (abort) begin
                        m_mode = M_IDLE;
                    end else begin
                        m_phase = m_phase + m_fcw;
                        m_idx++;
                        if (m_idx == seq.size()) begin
                            if (s_loop) begin
                                m_idx = 0; m_wrap = 1'b1; m_fcw = seq[0];
                            end else begin
                                m_mode = M_DONE;
                            end
                        end else begin
                            m_fcw = seq[m_idx];
                        end
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("phase",       phase,       m_phase);
            check("fcw",         fcw,         m_fcw);
            check("phase_valid", phase_valid, m_mode == M_RUN);
            check("busy",        busy,        m_mode == M_RUN);
            check("done",        done,        m_mode == M_DONE);
            check("cfg_ready",   cfg_ready,   m_mode == M_IDLE);
            check("sweep_wrap",  sweep_wrap,  m_wrap);
            if (done === 1'b1) done_cnt++;
            if (sweep_wrap === 1'b1) wrap_cnt++;
            if (busy === 1'b1 && fcw === 32'h1000_0000) saw_fcw_wrapped = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_cfg(input logic [31:0] st, input logic [31:0] sp, input logic [31:0] stp,
                             input logic [15:0] dw, input logic [31:0] p0, input logic lp);
        cfg_start_fcw = st; cfg_stop_fcw = sp; cfg_step_fcw = stp;
        cfg_dwell = dw; cfg_phase0 = p0; cfg_loop = lp;
    endtask

    task automatic cfg_and_start();
        cfg_valid = 1'b1; start = 1'b1;
        tick(1);
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    int          d0, w0, waited;
    logic [31:0] held;

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
        drive_cfg('0, '0, '0, '0, '0, 1'b0);
        tick(3);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset_phase", phase, 0);
        check("reset_fcw", fcw, 0);
        check("reset_cfg_ready", cfg_ready, 1);
        check("reset_busy", busy, 0);

        // Single-shot 3-step sweep, dwell 4, config then start in separate cycles.
        drive_cfg(32'h0100_0000, 32'h0300_0000, 32'h0100_0000, 16'd4, 32'h0, 1'b0);
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0; start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t1_first_fcw", fcw, 32'h0100_0000);
        tick(4);
        check("t1_second_fcw", fcw, 32'h0200_0000);
        tick(9);
        #1;
        check("t1_done_count", done_cnt, 1);
        check("t1_final_phase", phase, 32'h1800_0000);
        check("t1_final_fcw", fcw, 32'h0300_0000);
        check("t1_cfg_ready", cfg_ready, 1);

        // Looping sweep: wrap every 12 RUN cycles, phase continuous, then abort.
        w0 = wrap_cnt; d0 = done_cnt;
        drive_cfg(32'h0100_0000, 32'h0300_0000, 32'h0100_0000, 16'd4, 32'h0, 1'b1);
        cfg_and_start();
        tick(39);
        #1;
        check("t2_wrap_count", wrap_cnt - w0, 3);
        check("t2_fcw_after_wrap", fcw, 32'h0100_0000);
        check("t2_phase_continuous", phase, 32'h4B00_0000);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(3);
        #1;
        check("t2_abort_phase_frozen", phase, 32'h4B00_0000);
        check("t2_abort_idle", busy, 0);
        check("t2_no_done", done_cnt, d0);

        // step 0: phase alternates via natural wrap until aborted.
        d0 = done_cnt;
        drive_cfg(32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 16'd1, 32'hC000_0000, 1'b0);
        cfg_and_start();
        check("t3_phase_c1", phase, 32'hC000_0000);
        tick(1);
        check("t3_phase_c2", phase, 32'h4000_0000);
        tick(1);
        check("t3_phase_c3", phase, 32'hC000_0000);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        held = phase;
        tick(4);
        #1;
        check("t3_phase_frozen", phase, held);
        check("t3_no_done", done_cnt, d0);

        // Carry-out of fcw+step ends the sweep after the first dwell.
        d0 = done_cnt;
        drive_cfg(32'h2000_0000, 32'hFFFF_FFFF, 32'hF000_0000, 16'd3, 32'h0, 1'b0);
        cfg_and_start();
        tick(4);
        #1;
        check("t4_done_count", done_cnt, d0 + 1);
        check("t4_fcw_held", fcw, 32'h2000_0000);
        check("t4_phase", phase, 32'h6000_0000);
        check("t4_no_fcw_wrap", saw_fcw_wrapped, 0);

        // cfg_valid held across RUN: not accepted until IDLE.
        drive_cfg(32'h100, 32'h200, 32'h100, 16'd2, 32'h0, 1'b0);
        cfg_and_start();
        drive_cfg(32'h500, 32'h600, 32'h100, 16'd1, 32'h7, 1'b0);
        cfg_valid = 1'b1;
        check("t5_cfg_ready_low", cfg_ready, 0);
        tick(2);
        check("t5_run_keeps_old_cfg", fcw, 32'h200);
        waited = 0;
        while (cfg_ready !== 1'b1 && waited < 20) begin
            tick(1);
            waited++;
        end
        check("t5_cfg_ready_timeout", waited < 20, 1);
        tick(1);
        cfg_valid = 1'b0; start = 1'b1;
        drive_cfg('0, '0, '0, '0, '0, 1'b0);
        tick(1);
        start = 1'b0;
        check("t5_held_cfg_start_fcw", fcw, 32'h500);
        check("t5_held_cfg_phase0", phase, 32'h7);
        tick(4);

        // Config and start in the same cycle use the new values immediately.
        drive_cfg(32'hA00, 32'hA00, 32'h1, 16'd2, 32'h3, 1'b0);
        cfg_and_start();
        check("t5_bypass_fcw", fcw, 32'hA00);
        check("t5_bypass_phase0", phase, 32'h3);
        tick(4);

        // Reset mid-RUN, then a dwell-0 run behaves as dwell 1.
        d0 = done_cnt;
        drive_cfg(32'h1000, 32'hFFFF_0000, 32'h1000, 16'd5, 32'h55, 1'b1);
        cfg_and_start();
        tick(4);
        rst_n = 1'b0;
        tick(1);
        check("t6_reset_busy", busy, 0);
        check("t6_reset_phase", phase, 0);
        check("t6_reset_fcw", fcw, 0);
        check("t6_reset_cfg_ready", cfg_ready, 1);
        check("t6_reset_done", done, 0);
        rst_n = 1'b1;
        drive_cfg(32'h10, 32'h30, 32'h10, 16'd0, 32'h0, 1'b0);
        cfg_and_start();
        check("t6_dwell0_fcw1", fcw, 32'h10);
        tick(1);
        check("t6_dwell0_fcw2", fcw, 32'h20);
        tick(3);
        #1;
        check("t6_done_count", done_cnt, d0 + 1);
        check("t6_final_phase", phase, 32'h60);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
